// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (LS). Arbitrates in IDLE, latches the winning transaction,
// presents it with a req/gnt handshake and routes the response back to
// its owner. Fetch responses can be discarded by a branch flush.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        flush,
  // load/store requester
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wmask,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  state_t      state;
  logic        owner_if;
  logic        discard;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_inc;
  logic        starve_hit;
  logic        if_win;
  logic        ls_win;
  logic        drop_fetch;

  // Arbitration: LS wins unless it has starved a waiting fetch STARVE_MAX times.
  always_comb begin
    starve_hit = (starve_cnt == STARVE_LIMIT);
    starve_inc = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
    drop_fetch = discard || flush;
    if_win     = 1'b0;
    ls_win     = 1'b0;
    if ((state == IDLE) && !reset) begin
      if (if_req && (!ls_req || starve_hit)) begin
        if_win = 1'b1;
      end else if (ls_req) begin
        ls_win = 1'b1;
      end
    end
  end

  assign if_gnt = if_win;
  assign ls_gnt = ls_win;
  assign busy   = (state != IDLE);

  // Transaction FSM: latch winner, hold it on the port, deliver the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_if   <= 1'b0;
      discard    <= 1'b0;
      starve_cnt <= 4'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wmask  <= 4'h0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= 32'h0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            state      <= REQ;
            owner_if   <= 1'b1;
            discard    <= flush;
            starve_cnt <= 4'd0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 4'h0;
          end else if (ls_win) begin
            state      <= REQ;
            owner_if   <= 1'b0;
            discard    <= 1'b0;
            starve_cnt <= if_req ? starve_inc : 4'd0;
            mem_req    <= 1'b1;
            mem_we     <= ls_we;
            mem_addr   <= ls_addr;
            mem_wdata  <= ls_wdata;
            mem_wmask  <= ls_wmask;
          end
        end
        REQ: begin
          if (flush && owner_if) begin
            discard <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state   <= IDLE;
            discard <= 1'b0;
            if (owner_if) begin
              // a flush arriving together with the response still kills it
              if (!drop_fetch) begin
                if_rvalid <= 1'b1;
                if_rdata  <= mem_rdata;
              end
            end else begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= mem_we ? 32'h0 : mem_rdata;
            end
          end else if (flush && owner_if) begin
            discard <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Table-driven single transactions, hand-written multi-cycle sequences
// (starvation, stalls, reset mid-WAIT) and a randomized phase checked
// against a transaction-level reference model with its own memory image.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        flush;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wmask;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .flush(flush),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hard stop in case something wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rsp;
    int          flush_mode;   // 0 none, 1 with the grant, 2 in WAIT
    logic        exp_if_rv;
    logic        exp_ls_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req     = 1'b0;
    if_addr    = 32'h0;
    flush      = 1'b0;
    ls_req     = 1'b0;
    ls_we      = 1'b0;
    ls_addr    = 32'h0;
    ls_wdata   = 32'h0;
    ls_wmask   = 4'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // best-case memory: grant immediately, answer in the first WAIT cycle
  task automatic mem_auto();
    mem_gnt    = mem_req;
    mem_rvalid = busy && !mem_req;
    mem_rdata  = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_if_gnt"}, if_gnt, 1'b0);
    check_bit({tag, "_ls_gnt"}, ls_gnt, 1'b0);
    check_bit({tag, "_mem_req"}, mem_req, 1'b0);
    check_bit({tag, "_mem_we"}, mem_we, 1'b0);
    check_word({tag, "_mem_addr"}, mem_addr, 32'h0);
    check_word({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check_word({tag, "_mem_wmask"}, {28'h0, mem_wmask}, 32'h0);
    check_bit({tag, "_if_rvalid"}, if_rvalid, 1'b0);
    check_bit({tag, "_ls_rvalid"}, ls_rvalid, 1'b0);
    check_word({tag, "_if_rdata"}, if_rdata, 32'h0);
    check_word({tag, "_ls_rdata"}, ls_rdata, 32'h0);
    check_bit({tag, "_busy"}, busy, 1'b0);
  endtask

  // one complete transaction from a vector record, best-case memory timing
  task automatic apply_stimulus(input vec_t v);
    if_req   = !v.is_ls;
    if_addr  = v.addr;
    ls_req   = v.is_ls;
    ls_we    = v.we;
    ls_addr  = v.is_ls ? v.addr : 32'hFFFF_FFF0;
    ls_wdata = v.wdata;
    ls_wmask = v.wmask;
    flush    = (v.flush_mode == 1);
    sample();
    check_bit("vec_if_gnt", if_gnt, !v.is_ls);
    check_bit("vec_ls_gnt", ls_gnt, v.is_ls);
    next_cycle();
    if_req   = 1'b0;
    ls_req   = 1'b0;
    if_addr  = 32'hBAD0_0000;
    ls_addr  = 32'hBAD0_0004;
    ls_we    = ~v.we;
    ls_wdata = ~v.wdata;
    ls_wmask = ~v.wmask;
    flush    = 1'b0;
    mem_gnt  = 1'b1;
    sample();
    check_bit("vec_mem_req", mem_req, 1'b1);
    check_word("vec_mem_addr", mem_addr, v.addr);
    check_bit("vec_mem_we", mem_we, v.we);
    check_word("vec_mem_wmask", {28'h0, mem_wmask}, {28'h0, v.wmask});
    if (v.is_ls && v.we) check_word("vec_mem_wdata", mem_wdata, v.wdata);
    next_cycle();
    mem_gnt = 1'b0;
    if (v.flush_mode == 2) begin
      flush = 1'b1;
      sample();
      check_bit("vec_wait_mem_req", mem_req, 1'b0);
      next_cycle();
      flush = 1'b0;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = v.rsp;
    sample();
    check_bit("vec_busy_wait", busy, 1'b1);
    next_cycle();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h5555_0000;
    sample();
    check_bit("vec_if_rvalid", if_rvalid, v.exp_if_rv);
    check_bit("vec_ls_rvalid", ls_rvalid, v.exp_ls_rv);
    check_bit("vec_busy_done", busy, 1'b0);
    if (v.is_ls) check_word("vec_ls_rdata", ls_rdata, v.exp_rdata);
    else         check_word("vec_if_rdata", if_rdata, v.exp_rdata);
    next_cycle();
    sample();
    check_bit("vec_rvalid_pulse", if_rvalid || ls_rvalid, 1'b0);
    next_cycle();
  endtask

  // random-phase state: requesters, device memory, reference model
  logic        if_pend, ls_pend;
  logic [31:0] if_a, ls_a, ls_d;
  logic        ls_w;
  logic [3:0]  ls_m;
  logic [31:0] ref_mem [16];
  logic [31:0] dev_mem [16];
  logic        out_valid, out_is_if, out_we, out_discard;
  logic [31:0] out_addr, out_wdata, out_exp;
  logic [3:0]  out_wmask;
  logic        rsp_due, resp;
  int          streak;
  logic [31:0] last_if, last_ls;

  initial begin
    int      ngrants;
    int      pulses;
    logic    exp_if, exp_ls, pre_valid;
    logic [3:0] idx;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h12345678, 4'hF, 32'h5A5A5A5A, 0, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h12345678, 0, 1'b0, 1'b1, 32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'hAAAA5555, 2, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0, 4'h0, 32'h0BADF00D, 0, 1'b1, 1'b0, 32'h0BADF00D};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h11112222, 1, 1'b0, 1'b0, 32'h0BADF00D};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 32'h33334444, 0, 1'b1, 1'b0, 32'h33334444};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hCAFEBABE, 2, 1'b0, 1'b1, 32'hCAFEBABE};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0044, 32'hA5A50F0F, 4'h3, 32'h77777777, 0, 1'b0, 1'b1, 32'h0};

    // reset state, with both requesters asking while reset is held
    idle_inputs();
    reset  = 1'b1;
    if_req = 1'b1;
    ls_req = 1'b1;
    next_cycle();
    sample();
    check_reset_outputs("reset");
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    next_cycle();

    // table-driven single transactions
    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i]);

    // starvation: both requesters held high, best-case memory
    ngrants = 0;
    for (int c = 0; c < 80 && ngrants < 10; c++) begin
      if_req  = 1'b1;
      if_addr = 32'h0000_1000;
      ls_req  = 1'b1;
      ls_we   = 1'b0;
      ls_addr = 32'h0000_2000;
      mem_auto();
      sample();
      if (if_gnt || ls_gnt) begin
        check_bit("starve_one_gnt", if_gnt && ls_gnt, 1'b0);
        check_bit("starve_order_if", if_gnt, (ngrants % (STARVE_MAX + 1)) == STARVE_MAX);
        ngrants++;
      end
      next_cycle();
    end
    check_word("starve_grant_count", 32'(ngrants), 32'd10);
    if_req = 1'b0;
    ls_req = 1'b0;
    for (int c = 0; c < 20 && busy; c++) begin
      mem_auto();
      next_cycle();
    end
    check_bit("starve_drained", busy, 1'b0);
    idle_inputs();
    next_cycle();

    // stalls: mem_gnt late by 5 cycles, mem_rvalid late by 3 cycles
    ls_req   = 1'b1;
    ls_we    = 1'b0;
    ls_addr  = 32'h0000_0080;
    ls_wmask = 4'h0;
    sample();
    check_bit("stall_ls_gnt", ls_gnt, 1'b1);
    next_cycle();
    ls_req  = 1'b0;
    ls_addr = 32'hBAD0_0080;
    for (int c = 0; c < 5; c++) begin
      sample();
      check_bit("stall_req_held", mem_req, 1'b1);
      check_word("stall_req_addr", mem_addr, 32'h0000_0080);
      check_bit("stall_req_busy", busy, 1'b1);
      next_cycle();
    end
    mem_gnt = 1'b1;
    sample();
    check_bit("stall_req_gnt", mem_req, 1'b1);
    next_cycle();
    mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      check_bit("stall_wait_req", mem_req, 1'b0);
      check_word("stall_wait_addr", mem_addr, 32'h0000_0080);
      check_bit("stall_wait_busy", busy, 1'b1);
      check_bit("stall_wait_rvalid", ls_rvalid, 1'b0);
      next_cycle();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h600DD00D;
    sample();
    check_bit("stall_rsp_busy", busy, 1'b1);
    next_cycle();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    pulses = 0;
    sample();
    check_word("stall_ls_rdata", ls_rdata, 32'h600DD00D);
    check_bit("stall_done_busy", busy, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) sample();
      if (ls_rvalid) pulses++;
      check_bit("stall_no_if_rvalid", if_rvalid, 1'b0);
      next_cycle();
    end
    check_word("stall_pulse_count", 32'(pulses), 32'd1);

    // reset in the middle of a fetch WAIT
    if_req  = 1'b1;
    if_addr = 32'h0000_0500;
    sample();
    check_bit("rstwait_if_gnt", if_gnt, 1'b1);
    next_cycle();
    if_req  = 1'b0;
    mem_gnt = 1'b1;
    sample();
    next_cycle();
    mem_gnt = 1'b0;
    sample();
    check_bit("rstwait_in_wait", busy && !mem_req, 1'b1);
    next_cycle();
    reset = 1'b1;
    sample();
    check_reset_outputs("rstwait");
    next_cycle();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBADBAD00;
    sample();
    check_bit("rstwait_stale_busy", busy, 1'b0);
    next_cycle();
    mem_rvalid = 1'b0;
    sample();
    check_bit("rstwait_stale_if_rv", if_rvalid, 1'b0);
    check_bit("rstwait_stale_ls_rv", ls_rvalid, 1'b0);
    check_word("rstwait_stale_rdata", if_rdata, 32'h0);
    next_cycle();

    // randomized traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    if_pend = 1'b0; ls_pend = 1'b0;
    if_a = 32'h0; ls_a = 32'h0; ls_d = 32'h0; ls_w = 1'b0; ls_m = 4'h0;
    out_valid = 1'b0; out_is_if = 1'b0; out_we = 1'b0; out_discard = 1'b0;
    out_addr = 32'h0; out_wdata = 32'h0; out_exp = 32'h0; out_wmask = 4'h0;
    rsp_due = 1'b0; streak = 0; last_if = 32'h0; last_ls = 32'h0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!if_pend && ($urandom_range(0, 1) == 1)) begin
        if_pend = 1'b1;
        if_a    = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_pend && ($urandom_range(0, 1) == 1)) begin
        ls_pend = 1'b1;
        ls_a    = $urandom & 32'hFFFF_FFFC;
        ls_w    = ($urandom_range(0, 1) == 1);
        ls_d    = $urandom;
        ls_m    = 4'($urandom_range(0, 15));
      end
      if_req   = if_pend;
      if_addr  = if_pend ? if_a : $urandom;
      ls_req   = ls_pend;
      ls_addr  = ls_pend ? ls_a : $urandom;
      ls_we    = ls_w;
      ls_wdata = ls_d;
      ls_wmask = ls_m;

      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      resp       = 1'b0;
      if (mem_req) begin
        mem_gnt = ($urandom_range(0, 2) != 0);
      end else if (busy && ($urandom_range(0, 2) == 0)) begin
        resp       = 1'b1;
        mem_rvalid = 1'b1;
        idx        = mem_addr[5:2];
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) dev_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata = dev_mem[idx];
        end
      end
      flush = !resp && ($urandom_range(0, 9) == 0);

      sample();

      if (rsp_due) begin
        if (out_is_if) begin
          check_bit("rnd_if_rvalid", if_rvalid, !out_discard);
          check_bit("rnd_ls_rvalid_if", ls_rvalid, 1'b0);
          if (!out_discard) last_if = out_exp;
        end else begin
          check_bit("rnd_ls_rvalid", ls_rvalid, 1'b1);
          check_bit("rnd_if_rvalid_ls", if_rvalid, 1'b0);
          last_ls = out_we ? 32'h0 : out_exp;
        end
        out_valid = 1'b0;
        rsp_due   = 1'b0;
      end else begin
        check_bit("rnd_no_rvalid", if_rvalid || ls_rvalid, 1'b0);
      end
      check_word("rnd_if_rdata", if_rdata, last_if);
      check_word("rnd_ls_rdata", ls_rdata, last_ls);

      pre_valid = out_valid;
      check_bit("rnd_busy", busy, pre_valid);
      if (pre_valid && mem_req) begin
        check_word("rnd_mem_addr", mem_addr, out_addr);
        check_bit("rnd_mem_we", mem_we, out_we);
        check_word("rnd_mem_wmask", {28'h0, mem_wmask}, {28'h0, out_wmask});
        if (out_we) check_word("rnd_mem_wdata", mem_wdata, out_wdata);
      end
      rsp_due = resp && pre_valid;

      exp_if = 1'b0;
      exp_ls = 1'b0;
      if (!pre_valid) begin
        if (if_pend && ls_pend) begin
          if (streak == STARVE_MAX) exp_if = 1'b1;
          else                      exp_ls = 1'b1;
        end else begin
          exp_if = if_pend;
          exp_ls = ls_pend;
        end
      end
      check_bit("rnd_if_gnt", if_gnt, exp_if);
      check_bit("rnd_ls_gnt", ls_gnt, exp_ls);

      if (exp_if) begin
        out_valid   = 1'b1;
        out_is_if   = 1'b1;
        out_we      = 1'b0;
        out_addr    = if_a;
        out_wdata   = 32'h0;
        out_wmask   = 4'h0;
        out_discard = 1'b0;
        out_exp     = ref_mem[if_a[5:2]];
        streak      = 0;
        if_pend     = 1'b0;
      end else if (exp_ls) begin
        out_valid   = 1'b1;
        out_is_if   = 1'b0;
        out_we      = ls_w;
        out_addr    = ls_a;
        out_wdata   = ls_d;
        out_wmask   = ls_m;
        out_discard = 1'b0;
        out_exp     = ref_mem[ls_a[5:2]];
        if (ls_w)
          for (int b = 0; b < 4; b++)
            if (ls_m[b]) ref_mem[ls_a[5:2]][8*b +: 8] = ls_d[8*b +: 8];
        streak  = if_pend ? ((streak < 15) ? streak + 1 : 15) : 0;
        ls_pend = 1'b0;
      end
      if (flush && out_valid && out_is_if) out_discard = 1'b1;

      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-ported memory between the instruction fetch path and the load/store path. Each cycle it arbitrates the two requesters, latches the winner's transaction, drives it onto the memory port with a req/gnt handshake, and routes the response back to the owner. It sits between the fetch unit and register-file/load-store logic on one side and the unified memory on the other. It also discards in-flight fetch responses when a taken branch flushes fetch.

## Interface
- STARVE_MAX, 4: maximum consecutive load/store grants issued while if_req is pending; range 1..15.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch requests a read
- if_addr  in  32  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid (one-cycle pulse)
- if_rdata  out  32  fetch read data
- flush  in  1  discard any accepted, not-yet-returned fetch
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  32  load/store address
- ls_wdata  in  32  store data
- ls_wmask  in  4  store byte enables
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load data valid, or store completed (one-cycle pulse)
- ls_rdata  out  32  load data; 0 for stores
- mem_req  out  1  transaction presented to memory
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/32/32/4  latched transaction fields
- mem_gnt  in  1  memory accepts the presented transaction
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  32  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states and transitions:
  - IDLE: arbitrate among requesters.
    - Some req is high → winner's gnt = 1 (combinational, IDLE only); latch fields and owner; go to REQ.
    - No req → stay in IDLE.
  - REQ: hold mem_req = 1 with the latched fields stable. mem_gnt = 1 → WAIT.
  - WAIT: mem_req = 0. mem_rvalid = 1 → register the response to the owner; go to IDLE.
- Fetch transactions latch mem_we = 0 and mem_wmask = 0.
- Arbitration:
  - Load/store has priority.
  - starve_cnt (4 bits) counts LS grants made while if_req = 1.
  - When both requesters are high and starve_cnt == STARVE_MAX, fetch wins.
  - starve_cnt clears on any IF grant, and on any LS grant made while if_req = 0.
  - starve_cnt saturates and never wraps.
- Requesters hold req and fields until they see gnt. They may change them the cycle after gnt; the arbiter has already latched them.
- Flush:
  - A discard flag is set on flush = 1 if owner = IF and state is REQ or WAIT. It is also set if IF is granted in the same cycle as flush.
  - On completion with the flag set, if_rvalid stays 0; the flag then clears.
  - The memory transaction itself always completes; a presented request is never withdrawn.
  - flush has no effect on LS transactions or in IDLE with no IF grant.
- Response routing: if_rdata/ls_rdata update only on their own rvalid and hold otherwise. ls_rdata is loaded with 0 on store completion.
- Memory must not assert mem_rvalid in the same cycle as mem_gnt; mem_rvalid outside WAIT is ignored.

## Timing
- Reset values:
  - state IDLE; starve_cnt 0; discard 0.
  - mem_req, mem_we, if_rvalid, ls_rvalid, busy = 0.
  - mem_addr, mem_wdata, mem_wmask, if_rdata, ls_rdata = 0.
  - if_gnt and ls_gnt are 0 while reset is asserted.
- Reset mid-transaction returns to IDLE immediately. No rvalid is produced for the aborted transaction.
- Best-case latency, cycle numbers relative to the gnt cycle:
  - Cycle 0: gnt.
  - Cycle 1: mem_req, with mem_gnt = 1.
  - Cycle 2: WAIT, with mem_rvalid = 1.
  - Cycle 3: owner rvalid, state IDLE, next gnt possible.
- Throughput: at most one transaction per 3 cycles. Only one transaction is ever outstanding.
- mem_gnt stalls in REQ and mem_rvalid stalls in WAIT are unbounded. All mem_* outputs stay constant during stalls.

## Test plan
- Single fetch: if_req = 1, if_addr = 0x100; mem_gnt the cycle after mem_req; mem_rvalid next cycle with 0xDEADBEEF → if_gnt at cycle 0, mem_req at cycle 1, if_rvalid = 1 and if_rdata = 0xDEADBEEF at cycle 3.
- Store then load: ls_we = 1, addr 0x20, wdata 0x12345678, wmask 0xF, followed by a load from 0x20 returning 0x12345678 → mem_we/mem_wmask = 1/0xF, then 0/0; ls_rdata = 0 after the store; ls_rdata = 0x12345678 after the load.
- Starvation: if_req and ls_req held high continuously, STARVE_MAX = 4 → grant order LS, LS, LS, LS, IF, LS, …
- Flush: IF granted; flush = 1 while in WAIT; mem_rvalid = 1 with 0xAAAA5555 → if_rvalid stays 0; the next IF grant returns data normally.
- Stalls: mem_gnt held low 5 cycles, then mem_rvalid delayed 3 cycles → mem_addr stable throughout; busy = 1 until the rvalid cycle; exactly one owner rvalid pulse.
- Reset mid-WAIT: assert reset during WAIT → all outputs at reset values on the same cycle; a stale mem_rvalid after reset produces no rvalid.
